// File: rtl/t_flip_flop_counter.sv
// Bank of WIDTH T flip-flops with a selectable toggle source: a direct mask,
// or carry/borrow chains that turn the bank into a saturating or wrapping up/down counter.
module t_flip_flop_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] T,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_MASK = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

    mode_e            mode_sel;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [WIDTH-1:0] toggle;
    logic             all_ones;
    logic             all_zero;
    logic             tc_next;

    assign mode_sel = mode_e'(mode);
    assign all_ones = &Q;
    assign all_zero = ~|Q;

    // Bit i toggles when every lower bit is one (up) or zero (down).
    assign up_tog[0] = 1'b1;
    assign dn_tog[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign up_tog[i] = &Q[i-1:0];
        assign dn_tog[i] = ~|Q[i-1:0];
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        toggle  = '0;
        tc_next = 1'b0;
        if (en) begin
            unique case (mode_sel)
                MODE_MASK: toggle = T;
                MODE_UP: begin
                    tc_next = all_ones;
                    toggle  = (SATURATE && all_ones) ? '0 : up_tog;
                end
                MODE_DOWN: begin
                    tc_next = all_zero;
                    toggle  = (SATURATE && all_zero) ? '0 : dn_tog;
                end
                default: toggle = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            Q  <= RST_Q;
            tc <= 1'b0;
        end else if (load) begin
            Q  <= d;
            tc <= 1'b0;
        end else begin
            Q  <= Q ^ toggle;
            tc <= tc_next;
        end
    end

endmodule

// File: tb/tb_t_flip_flop_counter.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and are
// compared against directed expectations and an arithmetic reference model.
module tb_t_flip_flop_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] T;
    logic       load;
    logic [3:0] d;
    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, index 0 = wrapping, 1 = saturating.
    int mq[2];
    bit mtc[2];

    always #5 clk = ~clk;

    t_flip_flop_counter #(.WIDTH(4), .RESET_VALUE(32'd5), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .T(T),
        .load(load), .d(d), .Q(q_w), .tc(tc_w)
    );

    t_flip_flop_counter #(.WIDTH(4), .RESET_VALUE(32'd5), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .T(T),
        .load(load), .d(d), .Q(q_s), .tc(tc_s)
    );

    function automatic void model_step(int s);
        if (reset) begin
            mq[s] = 5; mtc[s] = 0;
        end else if (load) begin
            mq[s] = int'(d); mtc[s] = 0;
        end else if (!en || mode == 2'b00) begin
            mtc[s] = 0;
        end else if (mode == 2'b01) begin
            mq[s] = mq[s] ^ int'(T); mtc[s] = 0;
        end else if (mode == 2'b10) begin
            if (mq[s] == 15) begin
                mtc[s] = 1; mq[s] = (s == 1) ? 15 : 0;
            end else begin
                mtc[s] = 0; mq[s] = mq[s] + 1;
            end
        end else begin
            if (mq[s] == 0) begin
                mtc[s] = 1; mq[s] = (s == 1) ? 0 : 15;
            end else begin
                mtc[s] = 0; mq[s] = mq[s] - 1;
            end
        end
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic l, input logic [3:0] dv,
                         input logic e, input logic [1:0] m, input logic [3:0] t);
        reset = r; load = l; d = dv; en = e; mode = m; T = t;
    endtask

    task automatic test_reset();
        drive(1, 0, 4'h0, 0, 2'b00, 4'h0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) reset = 1'b0;
            tick();
            n_total += 2;
            if (q_w !== 4'h5 || tc_w !== 1'b0)
                $display("FAIL reset_hold[%0d] wrap: Q=%h tc=%b, expected Q=5 tc=0", k, q_w, tc_w);
            else n_pass++;
            if (q_s !== 4'h5 || tc_s !== 1'b0)
                $display("FAIL reset_hold[%0d] sat: Q=%h tc=%b, expected Q=5 tc=0", k, q_s, tc_s);
            else n_pass++;
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] ew[3]  = '{4'hF, 4'h0, 4'h1};
        logic       etw[3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] es[3]  = '{4'hF, 4'hF, 4'hF};
        logic       ets[3] = '{1'b0, 1'b1, 1'b1};
        drive(0, 1, 4'hE, 0, 2'b00, 4'h0);
        tick();
        n_total++;
        if (q_w !== 4'hE || tc_w !== 1'b0)
            $display("FAIL up_wrap load: Q=%h tc=%b, expected Q=e tc=0", q_w, tc_w);
        else n_pass++;
        drive(0, 0, 4'h0, 1, 2'b10, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total += 2;
            if (q_w !== ew[k] || tc_w !== etw[k])
                $display("FAIL up_wrap[%0d] wrap: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_w, tc_w, ew[k], etw[k]);
            else n_pass++;
            if (q_s !== es[k] || tc_s !== ets[k])
                $display("FAIL up_wrap[%0d] sat: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_s, tc_s, es[k], ets[k]);
            else n_pass++;
        end
    endtask

    task automatic test_down_sat();
        logic [3:0] es[4]  = '{4'h0, 4'h0, 4'h0, 4'h0};
        logic       ets[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] ew[4]  = '{4'h0, 4'hF, 4'hE, 4'hD};
        logic       etw[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        drive(0, 1, 4'h1, 0, 2'b00, 4'h0);
        tick();
        n_total++;
        if (q_s !== 4'h1 || tc_s !== 1'b0)
            $display("FAIL down_sat load: Q=%h tc=%b, expected Q=1 tc=0", q_s, tc_s);
        else n_pass++;
        drive(0, 0, 4'h0, 1, 2'b11, 4'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total += 2;
            if (q_s !== es[k] || tc_s !== ets[k])
                $display("FAIL down_sat[%0d] sat: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_s, tc_s, es[k], ets[k]);
            else n_pass++;
            if (q_w !== ew[k] || tc_w !== etw[k])
                $display("FAIL down_sat[%0d] wrap: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_w, tc_w, ew[k], etw[k]);
            else n_pass++;
        end
    endtask

    task automatic test_mask();
        logic [3:0] masks[2] = '{4'h3, 4'hF};
        logic [3:0] exp_q[2] = '{4'h9, 4'h6};
        drive(0, 1, 4'hA, 0, 2'b00, 4'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 4'h0, 1, 2'b01, masks[k]);
            tick();
            n_total += 2;
            if (q_w !== exp_q[k] || tc_w !== 1'b0)
                $display("FAIL mask[%0d] wrap: Q=%h tc=%b, expected Q=%h tc=0", k, q_w, tc_w, exp_q[k]);
            else n_pass++;
            if (q_s !== exp_q[k] || tc_s !== 1'b0)
                $display("FAIL mask[%0d] sat: Q=%h tc=%b, expected Q=%h tc=0", k, q_s, tc_s, exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_q[3] = '{4'h5, 4'hC, 4'hD};
        drive(0, 1, 4'h7, 0, 2'b00, 4'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      drive(1, 1, 4'hC, 1, 2'b10, 4'h0);
            else if (k == 1) drive(0, 1, 4'hC, 1, 2'b10, 4'h0);
            else             drive(0, 0, 4'h0, 1, 2'b10, 4'h0);
            tick();
            n_total++;
            if (q_w !== exp_q[k] || tc_w !== 1'b0)
                $display("FAIL priority[%0d]: Q=%h tc=%b, expected Q=%h tc=0", k, q_w, tc_w, exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 4'h0, 0, 2'b00, 4'h0);
        tick();
        drive(0, 0, 4'h0, 1, 2'b10, 4'h0);
        for (int k = 0; k < 3; k++) tick();
        n_total++;
        if (q_w !== 4'h3)
            $display("FAIL reset_mid count: Q=%h, expected Q=3", q_w);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (q_w !== 4'h5 || tc_w !== 1'b0)
            $display("FAIL reset_mid abort: Q=%h tc=%b, expected Q=5 tc=0", q_w, tc_w);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (q_w !== 4'h6 || tc_w !== 1'b0)
            $display("FAIL reset_mid resume: Q=%h tc=%b, expected Q=6 tc=0", q_w, tc_w);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                  4'($urandom), ($urandom_range(0, 7) != 0),
                  2'($urandom), 4'($urandom));
            tick();
            n_total += 2;
            if (q_w !== 4'(mq[0]) || tc_w !== mtc[0])
                $display("FAIL random[%0d] wrap: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_w, tc_w, 4'(mq[0]), mtc[0]);
            else n_pass++;
            if (q_s !== 4'(mq[1]) || tc_s !== mtc[1])
                $display("FAIL random[%0d] sat: Q=%h tc=%b, expected Q=%h tc=%b",
                         k, q_s, tc_s, 4'(mq[1]), mtc[1]);
            else n_pass++;
        end
    endtask

    initial begin
        mq[0] = 0; mq[1] = 0; mtc[0] = 0; mtc[1] = 0;
        drive(1, 0, 4'h0, 0, 2'b00, 4'h0);
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_mask();
        test_priority();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
